mac_array_acc: RTL and testbench
================================

Name: mac_array_acc

Overview:
Parametrised successor to the 16-lane int8/int4 MAC array. It computes LANES dot products per beat, each between one A row and a shared B vector, in int8 or packed int4. Results accumulate into a DEPTH-entry, slot-indexed accumulator buffer per lane, a flop array that replaces the clock-phase latch array. Completed accumulations drain through a valid/ready output port to the downstream result buffer.

Parameters:
LANES, 16, number of parallel dot-product lanes (A rows)
K, 32, bytes per row vector (K int8 elements or 2K int4 elements)
ACC_W, 24, signed accumulator / output width per lane
DEPTH, 16, accumulator slots per lane; power of 2, at least 2

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
clr  input  1  synchronous flush of pointer, pipeline and output register
in_valid  input  1  input beat valid
in_ready  output  1  input beat accepted when in_valid && in_ready
in_first  input  1  beat overwrites its slot instead of accumulating
in_last  input  1  beat completes its slot; result goes to output
mode  input  2  0 = int8, 1 = int4, 2/3 = illegal (products forced to 0)
a_vec  input  LANES*K*8  lane i occupies bits [i*K*8 +: K*8]
b_vec  input  K*8  shared operand vector
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  LANES*ACC_W  lane i result at [i*ACC_W +: ACC_W]
out_idx  output  $clog2(DEPTH)  slot index of the result
out_sat  output  LANES  per-lane saturation occurred during this slot's accumulation

Behaviour:
- Reset: all accumulators 0, slot pointer 0, pipeline valids 0, out_valid 0, out_data 0, out_idx 0, out_sat 0, per-slot sat flags 0.
- Pipeline: S1 registers per-lane dot product with slot, first, last and mode; S2 does read-modify-write of acc[lane][slot].
- Advance condition: adv = !(out_valid && !out_ready) && !clr. in_ready = adv. All stages hold when adv is 0.
- Slot pointer: increments (mod DEPTH) on every accepted beat; wraps DEPTH-1 -> 0. The same slot is revisited only after DEPTH beats, so there is no RAW hazard.
- int8: sum over k of signed a[k]*signed b[k]; 16-bit products, sum sign-extended to ACC_W.
- int4: each byte holds two signed nibbles, low nibble = even element. Sum of 2K nibble products.
- Illegal mode: dot product 0. Accumulators stay unchanged apart from the first/last semantics.
- S2 new value: first ? dot : sat(acc + dot), saturating to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- Per-slot sat flag: first resets it to the saturation result of the current add; otherwise it is OR-ed with it.
- Latency: beat accepted at edge t -> S1 at t+1 -> acc written at t+2. For a last beat, out_valid rises at t+2 with the written value, out_idx = slot and out_sat = slot flags.
- Output register holds stable while out_valid && !out_ready. A new result may load on the same edge the old one is consumed; the output supports full throughput, 1 result/cycle.
- in_first && in_last on one beat: result = dot, no accumulation.
- clr: slot pointer 0; S1/S2 valids 0; out_valid 0. Accumulator contents are undefined afterwards, so the next use of each slot must carry first. clr dominates in_valid on the same cycle.
- Reset asserted mid-operation: everything returns to reset values immediately, and in-flight beats are lost.

Decomposition:
- Shared package mac_pkg: mode encodings (MODE_INT8, MODE_INT4), a saturating-add function, and a clog2 helper constant.
- Sub-module mac_dot_lane: one lane's int8/int4 dot product, combinational, instantiated LANES times under generate. The S1 register lives in the parent.

Test Plan:
- int8, all a=1, b=2, single beat first+last -> out_valid 2 cycles after accept, every lane out_data=64, out_idx=0, out_sat=0.
- int4, a bytes 0x11, b bytes 0x22, first+last -> every lane 128. Then a bytes 0xFF (-1,-1), b bytes 0x22 -> every lane -128.
- Accumulate: 48 continuous beats, int8, a=1, b=1; first on beats 0-15, last on beats 32-47 -> 16 results, idx 0..15, each 96, one per cycle.
- Saturation: a=127, b=127 int8 on slot 0 for 17 passes (first on pass 0) -> out_data=8388607, out_sat all ones. With a=-128, b=127 -> -8388608.
- Backpressure: out_ready low 5 cycles with results pending -> in_ready low, out_data/out_idx stable, no beat lost or duplicated vs reference model.
- Mid-stream: clr, then separately rst_n pulse, during 10-beat burst -> outputs zero/invalid next cycle; restart with first beats gives correct sums from slot 0.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC array: operand mode encodings, saturating add
// and index-width helper.
package mac_pkg;

  typedef enum logic [1:0] {
    MODE_INT8 = 2'd0,
    MODE_INT4 = 2'd1,
    MODE_RSV2 = 2'd2,
    MODE_RSV3 = 2'd3
  } mac_mode_e;

  localparam int MAX_ACC_W = 64;
  localparam int SUM_W     = MAX_ACC_W + 1;

  typedef struct packed {
    logic [MAX_ACC_W-1:0] value;
    logic                 sat;
  } sat_res_t;

  // Callers sign-extend their ACC_W-wide operands to MAX_ACC_W; w is the
  // real accumulator width the result is clamped to.
  function automatic sat_res_t sat_add(input logic signed [MAX_ACC_W-1:0] a,
                                       input logic signed [MAX_ACC_W-1:0] b,
                                       input int w);
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] one;
    logic signed [SUM_W-1:0] hi;
    logic signed [SUM_W-1:0] lo;
    sat_res_t res;
    one    = '0;
    one[0] = 1'b1;
    hi     = (one <<< (w - 1)) - one;
    lo     = -hi - one;
    sum    = SUM_W'(a) + SUM_W'(b);
    if (sum > hi) begin
      res.value = hi[MAX_ACC_W-1:0];
      res.sat   = 1'b1;
    end else if (sum < lo) begin
      res.value = lo[MAX_ACC_W-1:0];
      res.sat   = 1'b1;
    end else begin
      res.value = sum[MAX_ACC_W-1:0];
      res.sat   = 1'b0;
    end
    return res;
  endfunction

  function automatic int idx_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mac_dot_lane.sv
// One lane's combinational dot product of an A row against the shared B
// vector, as K int8 products or 2K packed int4 products.
module mac_dot_lane
  import mac_pkg::*;
#(
  parameter int K     = 32,
  parameter int ACC_W = 24
) (
  input  logic [K*8-1:0]          a_row,
  input  logic [K*8-1:0]          b_vec,
  input  logic [1:0]              mode,
  output logic signed [ACC_W-1:0] dot
);

  logic [15:0] prod8    [K];
  logic [7:0]  prod4_lo [K];
  logic [7:0]  prod4_hi [K];

  // Operands are sign-extended to the product width, so an unsigned multiply
  // truncated to that width yields the exact signed product.
  for (genvar gi = 0; gi < K; gi++) begin : gen_elem
    logic [7:0] a_byte;
    logic [7:0] b_byte;
    assign a_byte       = a_row[gi*8 +: 8];
    assign b_byte       = b_vec[gi*8 +: 8];
    assign prod8[gi]    = {{8{a_byte[7]}}, a_byte} * {{8{b_byte[7]}}, b_byte};
    assign prod4_lo[gi] = {{4{a_byte[3]}}, a_byte[3:0]} * {{4{b_byte[3]}}, b_byte[3:0]};
    assign prod4_hi[gi] = {{4{a_byte[7]}}, a_byte[7:4]} * {{4{b_byte[7]}}, b_byte[7:4]};
  end

  logic signed [ACC_W-1:0] sum8;
  logic signed [ACC_W-1:0] sum4;

  always_comb begin
    sum8 = '0;
    sum4 = '0;
    for (int k = 0; k < K; k++) begin
      sum8 = sum8 + {{(ACC_W-16){prod8[k][15]}}, prod8[k]};
      sum4 = sum4 + {{(ACC_W-8){prod4_lo[k][7]}}, prod4_lo[k]}
                  + {{(ACC_W-8){prod4_hi[k][7]}}, prod4_hi[k]};
    end
  end

  always_comb begin
    dot = '0;
    case (mode)
      MODE_INT8: dot = sum8;
      MODE_INT4: dot = sum4;
      default:   dot = '0;
    endcase
  end

endmodule

// File: rtl/mac_array_acc.sv
// LANES parallel dot products accumulated into per-lane slot buffers; a last
// beat publishes the slot through a valid/ready output register.
module mac_array_acc
  import mac_pkg::*;
#(
  parameter int LANES = 16,
  parameter int K     = 32,
  parameter int ACC_W = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_first,
  input  logic                     in_last,
  input  logic [1:0]               mode,
  input  logic [LANES*K*8-1:0]     a_vec,
  input  logic [K*8-1:0]           b_vec,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*ACC_W-1:0]   out_data,
  output logic [$clog2(DEPTH)-1:0] out_idx,
  output logic [LANES-1:0]         out_sat
);

  localparam int IDX_W = idx_width(DEPTH);

  logic             adv;
  logic             accept;
  logic             s2_fire;
  logic             out_load;
  logic [IDX_W-1:0] slot_ptr_reg;
  logic             s1_valid_reg;
  logic [IDX_W-1:0] s1_slot_reg;
  logic             s1_first_reg;
  logic             s1_last_reg;
  logic             out_valid_reg;
  logic [IDX_W-1:0] out_idx_reg;

  // The whole pipeline freezes while a result waits on the consumer.
  assign adv      = !(out_valid_reg && !out_ready) && !clr;
  assign in_ready = adv;
  assign accept   = in_valid && adv;
  assign s2_fire  = adv && s1_valid_reg;
  assign out_load = s2_fire && s1_last_reg;

  assign out_valid = out_valid_reg;
  assign out_idx   = out_idx_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_ptr_reg  <= '0;
      s1_valid_reg  <= 1'b0;
      s1_slot_reg   <= '0;
      s1_first_reg  <= 1'b0;
      s1_last_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      out_idx_reg   <= '0;
    end else if (clr) begin
      slot_ptr_reg  <= '0;
      s1_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_idx_reg   <= '0;
    end else if (adv) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_slot_reg  <= slot_ptr_reg;
        s1_first_reg <= in_first;
        s1_last_reg  <= in_last;
        slot_ptr_reg <= slot_ptr_reg + IDX_W'(1);
      end
      out_valid_reg <= out_load;
      if (out_load) begin
        out_idx_reg <= s1_slot_reg;
      end
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : gen_lane
    logic signed [ACC_W-1:0] dot_next;
    logic signed [ACC_W-1:0] s1_dot_reg;
    logic        [ACC_W-1:0] acc_rd;
    logic        [ACC_W-1:0] acc_next;
    logic                    sat_next;
    logic        [ACC_W-1:0] acc_mem [DEPTH];
    logic        [DEPTH-1:0] sat_mem;
    logic        [ACC_W-1:0] out_lane_reg;
    logic                    out_sat_reg;
    sat_res_t                add_res;
    logic                    add_hi_unused;

    mac_dot_lane #(
      .K     (K),
      .ACC_W (ACC_W)
    ) u_dot (
      .a_row (a_vec[gi*K*8 +: K*8]),
      .b_vec (b_vec),
      .mode  (mode),
      .dot   (dot_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_dot_reg <= '0;
      end else if (accept) begin
        s1_dot_reg <= dot_next;
      end
    end

    // The pointer revisits a slot only after DEPTH beats, so this read never
    // races a pending write to the same slot.
    assign acc_rd        = acc_mem[s1_slot_reg];
    assign add_res       = sat_add({{(MAX_ACC_W-ACC_W){acc_rd[ACC_W-1]}}, acc_rd},
                                   {{(MAX_ACC_W-ACC_W){s1_dot_reg[ACC_W-1]}}, s1_dot_reg},
                                   ACC_W);
    assign add_hi_unused = ^add_res.value[MAX_ACC_W-1:ACC_W];

    always_comb begin
      acc_next = add_res.value[ACC_W-1:0];
      sat_next = sat_mem[s1_slot_reg] | add_res.sat;
      if (s1_first_reg) begin
        acc_next = s1_dot_reg;
        sat_next = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int d = 0; d < DEPTH; d++) begin
          acc_mem[d] <= '0;
        end
        sat_mem <= '0;
      end else if (s2_fire) begin
        acc_mem[s1_slot_reg] <= acc_next;
        sat_mem[s1_slot_reg] <= sat_next;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_lane_reg <= '0;
        out_sat_reg  <= 1'b0;
      end else if (clr) begin
        out_lane_reg <= '0;
        out_sat_reg  <= 1'b0;
      end else if (out_load) begin
        out_lane_reg <= acc_next;
        out_sat_reg  <= sat_next;
      end
    end

    assign out_data[gi*ACC_W +: ACC_W] = out_lane_reg;
    assign out_sat[gi]                 = out_sat_reg;
  end

endmodule

// File: tb/tb_mac_array_acc.sv
// Directed-vector bench for mac_array_acc: the driver queues hand-computed
// results, an independent monitor pops and compares each output handshake.
module tb_mac_array_acc;

  localparam int LANES = 16;
  localparam int K     = 32;
  localparam int ACC_W = 24;
  localparam int DEPTH = 16;
  localparam int IDX_W = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   clr;
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_first;
  logic                   in_last;
  logic [1:0]             mode;
  logic [LANES*K*8-1:0]   a_vec;
  logic [K*8-1:0]         b_vec;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*ACC_W-1:0] out_data;
  logic [IDX_W-1:0]       out_idx;
  logic [LANES-1:0]       out_sat;

  typedef struct packed {
    logic [IDX_W-1:0]       idx;
    logic [LANES*ACC_W-1:0] data;
    logic [LANES-1:0]       sat;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             mon_e;
  int               pop_cyc[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  int               cyc     = 0;
  logic [IDX_W-1:0] tb_ptr;

  mac_array_acc #(
    .LANES (LANES),
    .K     (K),
    .ACC_W (ACC_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .in_last   (in_last),
    .mode      (mode),
    .a_vec     (a_vec),
    .b_vec     (b_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [LANES*K*8-1:0] ramp_a(input int base);
    logic [LANES*K*8-1:0] r;
    int v;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      v = base + i;
      for (int k = 0; k < K; k++) r[(i*K+k)*8 +: 8] = v[7:0];
    end
    return r;
  endfunction

  function automatic logic [LANES*K*8-1:0] fill_a(input logic [7:0] v);
    logic [LANES*K*8-1:0] r;
    for (int j = 0; j < LANES*K; j++) r[j*8 +: 8] = v;
    return r;
  endfunction

  function automatic logic [K*8-1:0] fill_b(input logic [7:0] v);
    logic [K*8-1:0] r;
    for (int k = 0; k < K; k++) r[k*8 +: 8] = v;
    return r;
  endfunction

  // Lane i expects mul*(base+i); mul = 0 with base = v gives a uniform v.
  function automatic logic [LANES*ACC_W-1:0] ramp_d(input int mul, input int base);
    logic [LANES*ACC_W-1:0] r;
    int v;
    for (int i = 0; i < LANES; i++) begin
      v = mul * (base + i);
      r[i*ACC_W +: ACC_W] = v[ACC_W-1:0];
    end
    return r;
  endfunction

  function automatic logic [LANES*ACC_W-1:0] fill_d(input int v);
    logic [LANES*ACC_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*ACC_W +: ACC_W] = v[ACC_W-1:0];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_data(input string name, input logic [LANES*ACC_W-1:0] act,
                            input logic [LANES*ACC_W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every output handshake must match the oldest entry.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL result_unexpected: got idx=%0d data=%h, required no result",
                 out_idx, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        pop_cyc.push_back(cyc);
        if (out_idx !== mon_e.idx || out_data !== mon_e.data || out_sat !== mon_e.sat) begin
          n_fail++;
          $display("[TB] FAIL result: got idx=%0d sat=%h data=%h, required idx=%0d sat=%h data=%h",
                   out_idx, out_sat, out_data, mon_e.idx, mon_e.sat, mon_e.data);
        end else begin
          $display("[TB] result idx=%0d lane0=%0h lane15=%0h sat=%h ok", out_idx,
                   out_data[0 +: ACC_W], out_data[15*ACC_W +: ACC_W], out_sat);
        end
      end
    end
  end

  task automatic beat(input logic [LANES*K*8-1:0] a, input logic [K*8-1:0] b,
                      input logic [1:0] m, input logic f, input logic l,
                      input logic [LANES*ACC_W-1:0] ed, input logic [LANES-1:0] es);
    int   waited;
    bit   done;
    exp_t e;
    waited   = 0;
    done     = 0;
    a_vec    = a;
    b_vec    = b;
    mode     = m;
    in_first = f;
    in_last  = l;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        done = 1;
        if (l) begin
          e.idx  = tb_ptr;
          e.data = ed;
          e.sat  = es;
          exp_q.push_back(e);
        end
        tb_ptr = tb_ptr + 1'b1;
      end else if (waited >= 100) begin
        done = 1;
        n_tests++;
        n_fail++;
        $display("[TB] FAIL beat_timeout: got in_ready low 100 cycles, required accept");
      end
      waited++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    exp_q.delete();
    tb_ptr = '0;
  endtask

  logic [LANES*ACC_W-1:0] hold_data;
  logic [IDX_W-1:0]       hold_idx;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    mode = 2'd0; a_vec = '0; b_vec = '0; out_ready = 1'b1; tb_ptr = '0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_idx", out_idx, 0);
    check("reset_out_sat", out_sat, 0);
    check_data("reset_out_data", out_data, '0);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // int8 single beat: 32 * 1 * 2 = 64, visible two cycles after accept
    beat(fill_a(8'd1), fill_b(8'd2), 2'd0, 1, 1, fill_d(64), '0);
    @(negedge clk);
    check("latency_cycle1_valid", out_valid, 0);
    @(negedge clk);
    check("latency_cycle2_valid", out_valid, 1);
    @(posedge clk); #1;

    // int4: 0x11*0x22 -> 2 nibble products of 2 per byte -> 128; 0xFF -> -128
    beat(fill_a(8'h11), fill_b(8'h22), 2'd1, 1, 1, fill_d(128), '0);
    beat(fill_a(8'hFF), fill_b(8'h22), 2'd1, 1, 1, fill_d(-128), '0);
    // nibble pairing: (-1*1) + (1*2) = 1 per byte -> 32
    beat(fill_a(8'h1F), fill_b(8'h21), 2'd1, 1, 1, fill_d(32), '0);
    // int8 lane ramp: lane i a = i-8, b = 3 -> 96*(i-8)
    beat(ramp_a(-8), fill_b(8'd3), 2'd0, 1, 1, ramp_d(96, -8), '0);

    // Illegal modes contribute 0 and leave a live accumulator untouched
    beat(fill_a(8'd1), fill_b(8'd1), 2'd0, 1, 0, '0, '0);
    for (int s = 1; s < DEPTH; s++) beat(fill_a(8'd1), fill_b(8'd1), 2'd2, 1, 1, '0, '0);
    beat(fill_a(8'd1), fill_b(8'd1), 2'd3, 0, 1, fill_d(32), '0);
    wait_drain();

    // 48 beats, three per slot: 3 * 32 = 96, one result per cycle
    do_clr();
    pop_cyc.delete();
    for (int j = 0; j < 48; j++)
      beat(fill_a(8'd1), fill_b(8'd1), 2'd0, j < 16, j >= 32, fill_d(96), '0);
    wait_drain();
    check("stream_result_count", pop_cyc.size(), 16);
    if (pop_cyc.size() == 16) check("stream_result_span", pop_cyc[15] - pop_cyc[0], 15);

    // 17 passes of 127*127*32 = 516128 exceed 2^23-1; likewise negative
    for (int p = 0; p < 17; p++)
      for (int s = 0; s < DEPTH; s++)
        beat(fill_a(8'd127), fill_b(8'd127), 2'd0, p == 0, p == 16, fill_d(8388607), '1);
    for (int p = 0; p < 17; p++)
      for (int s = 0; s < DEPTH; s++)
        beat(fill_a(8'h80), fill_b(8'd127), 2'd0, p == 0, p == 16, fill_d(-8388608), '1);
    // first clears the sticky saturation flag
    for (int s = 0; s < DEPTH; s++)
      beat(fill_a(8'd1), fill_b(8'd1), 2'd0, 1, 1, fill_d(32), '0);
    wait_drain();

    // Backpressure: consumer stalls 5 cycles mid-burst
    fork
      begin
        for (int j = 0; j < 10; j++)
          beat(ramp_a(j), fill_b(8'd2), 2'd0, 1, 1, ramp_d(64, j), '0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_out_valid", out_valid, 1);
        check("bp_in_ready", in_ready, 0);
        hold_data = out_data;
        hold_idx  = out_idx;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          check("bp_in_ready_hold", in_ready, 0);
          check("bp_idx_stable", out_idx, hold_idx);
          check_data("bp_data_stable", out_data, hold_data);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // clr in the middle of a burst; clr also blocks the beat offered with it
    for (int j = 0; j < 4; j++)
      beat(ramp_a(j + 1), fill_b(8'd1), 2'd0, 1, 1, ramp_d(32, j + 1), '0);
    a_vec = ramp_a(5); b_vec = fill_b(8'd1); in_first = 1'b1; in_last = 1'b1;
    in_valid = 1'b1; clr = 1'b1;
    @(negedge clk);
    check("clr_in_ready", in_ready, 0);
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    tb_ptr = '0;
    @(negedge clk);
    check("clr_out_valid", out_valid, 0);
    check("clr_out_idx", out_idx, 0);
    check("clr_out_sat", out_sat, 0);
    check_data("clr_out_data", out_data, '0);
    @(posedge clk); #1;
    for (int j = 4; j < 10; j++)
      beat(ramp_a(j + 1), fill_b(8'd1), 2'd0, 1, 1, ramp_d(32, j + 1), '0);
    wait_drain();

    // Asynchronous reset pulse mid-burst
    for (int j = 0; j < 4; j++)
      beat(ramp_a(j), fill_b(8'd1), 2'd0, 1, 1, ramp_d(32, j), '0);
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", out_valid, 0);
    check_data("rst_async_data", out_data, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    tb_ptr = '0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_idx", out_idx, 0);
    @(posedge clk); #1;
    // slot 0 was zeroed by reset, so a non-first beat yields its own dot
    beat(fill_a(8'd1), fill_b(8'd1), 2'd0, 0, 1, fill_d(32), '0);
    beat(fill_a(8'd2), fill_b(8'd1), 2'd0, 1, 1, fill_d(64), '0);
    beat(fill_a(8'd3), fill_b(8'd1), 2'd0, 1, 1, fill_d(96), '0);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
